// File: rtl/spectrum_frame_ctrl.sv
// Frame sequencer for a double-buffered FFT magnitude spectrum RAM.
// Optional COLLECT idle timeout enabled by defining SPEC_FRAME_TIMEOUT_EN.
module spectrum_frame_ctrl #(
  parameter int unsigned N_BINS      = 8192,
  parameter int unsigned TIMEOUT_CYC = 1048575
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run_en,
  output logic        fft_start,
  input  logic        mag_valid,
  input  logic [12:0] mag_addr,
  input  logic        rd_busy,
  output logic        wr_en,
  output logic [13:0] wr_addr,
  output logic        rd_bank,
  output logic        frame_done,
  output logic [15:0] frame_cnt,
  output logic        sync_err,
  output logic        overrun,
  input  logic        clr_flags
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_COLLECT,
    S_SWAP,
    S_WAIT_RD
  } state_t;

  localparam logic [12:0] LAST_IDX = 13'(N_BINS - 1);

  state_t      r_state;
  state_t      w_next;
  logic        r_wr_bank;
  logic [12:0] r_exp_idx;
  logic [15:0] r_frame_cnt;
  logic        r_sync_err;
  logic        r_overrun;

  logic        w_collect;
  logic        w_hit;
  logic        w_miss;
  logic        w_stray;
  logic        w_timeout;
  logic        w_swap;

  assign w_collect = (r_state == S_COLLECT);
  assign w_hit     = w_collect && mag_valid && (mag_addr == r_exp_idx);
  assign w_miss    = w_collect && mag_valid && (mag_addr != r_exp_idx);
  assign w_stray   = !w_collect && mag_valid;

`ifdef SPEC_FRAME_TIMEOUT_EN
  logic [19:0] r_idle_cnt;

  // Counts consecutive COLLECT cycles without a bin; fires on the TIMEOUT_CYC-th.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle_cnt <= '0;
    end else if (!w_collect || mag_valid) begin
      r_idle_cnt <= '0;
    end else begin
      r_idle_cnt <= r_idle_cnt + 20'd1;
    end
  end

  assign w_timeout = w_collect && !mag_valid && (r_idle_cnt == 20'(TIMEOUT_CYC - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_swap = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (run_en) begin
          w_next = S_START;
        end
      end
      S_START: begin
        w_next = S_COLLECT;
      end
      S_COLLECT: begin
        if (w_miss || w_timeout) begin
          w_next = S_IDLE;
        end else if (w_hit && (mag_addr == LAST_IDX)) begin
          w_next = S_SWAP;
        end
      end
      S_SWAP, S_WAIT_RD: begin
        // Swap is only legal while the reader is off the read bank.
        if (!rd_busy) begin
          w_swap = 1'b1;
          w_next = run_en ? S_START : S_IDLE;
        end else begin
          w_next = S_WAIT_RD;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exp_idx   <= '0;
      r_wr_bank   <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      if (r_state == S_START) begin
        r_exp_idx <= '0;
      end else if (w_hit) begin
        r_exp_idx <= r_exp_idx + 13'd1;
      end
      if (w_swap) begin
        r_wr_bank   <= ~r_wr_bank;
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  // Sticky flags: a coincident set beats clr_flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_err <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if (w_miss || w_timeout) begin
        r_sync_err <= 1'b1;
      end else if (clr_flags) begin
        r_sync_err <= 1'b0;
      end
      if (w_stray) begin
        r_overrun <= 1'b1;
      end else if (clr_flags) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign fft_start  = (r_state == S_START);
  assign frame_done = w_swap;
  assign wr_en      = w_hit;
  assign wr_addr    = w_hit ? {r_wr_bank, mag_addr} : '0;
  assign rd_bank    = ~r_wr_bank;
  assign frame_cnt  = r_frame_cnt;
  assign sync_err   = r_sync_err;
  assign overrun    = r_overrun;

endmodule
